// File: rtl/eth_tlp_extract_pkg.sv
// Shared types for the Ethernet TLP extract stage.
// FIFO word layout, encapsulation size and parser states.
package eth_tlp_pkg;

    localparam int ENCAP_BYTES = 44;

    typedef struct packed {
        logic [7:0]  keep;
        logic [63:0] data;
        logic        last;
        logic        user;
    } fifo_word_t;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        FIRST = 2'd1,
        BODY  = 2'd2,
        TAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/eth_tlp_extract.sv
// Strips Ethernet/IPv4/UDP encapsulation from tap FIFO words and
// realigns the DW-aligned TLP by one DW onto a 64-bit AXI4-Stream.
module eth_tlp_extract
    import eth_tlp_pkg::*;
#(
    parameter int HDR_WORDS    = 5,
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [73:0]               dout,
    input  logic                      empty,
    output logic                      rd_en,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [31:0]               pkt_cnt,
    output logic [31:0]               drop_cnt
);

    localparam logic [3:0] LAST_HDR = 4'(HDR_WORDS - 1);

    fifo_word_t  w;
    state_t      state;
    logic [3:0]  count;
    logic        err_acc;
    logic [31:0] hold;
    logic        can_emit;
    logic        accept;
    logic        pop;

    assign w = fifo_word_t'(dout);

    // The output register is the only buffer, so pops wait for a free slot.
    always_comb begin
        can_emit = !m_axis_tvalid || m_axis_tready;
        accept   = can_emit && (state != TAIL);
        pop      = !empty && accept && !user_reset;
        rd_en    = pop;
    end

    // Frame parser, realignment and registered stream output.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state         <= HDR;
            count         <= '0;
            err_acc       <= 1'b0;
            hold          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            unique case (state)
                HDR: begin
                    if (pop) begin
                        if (w.last) begin
                            drop_cnt <= drop_cnt + 32'd1;
                            count    <= '0;
                            err_acc  <= 1'b0;
                        end else begin
                            err_acc <= err_acc | w.user;
                            if (count == LAST_HDR) begin
                                count <= '0;
                                state <= FIRST;
                            end else begin
                                count <= count + 4'd1;
                            end
                        end
                    end
                end

                FIRST: begin
                    if (pop) begin
                        hold <= w.data[63:32];
                        if (w.last) begin
                            err_acc <= 1'b0;
                            state   <= HDR;
                            if (|w.keep[7:4]) begin
                                m_axis_tdata  <= {32'h0, w.data[63:32]};
                                m_axis_tkeep  <= 8'h0F;
                                m_axis_tlast  <= 1'b1;
                                m_axis_tuser  <= err_acc | w.user;
                                m_axis_tvalid <= 1'b1;
                                pkt_cnt       <= pkt_cnt + 32'd1;
                            end else begin
                                drop_cnt <= drop_cnt + 32'd1;
                            end
                        end else begin
                            err_acc <= err_acc | w.user;
                            state   <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (pop) begin
                        m_axis_tdata  <= {w.data[31:0], hold};
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tvalid <= 1'b1;
                        hold          <= w.data[63:32];
                        if (w.last && !(|w.keep[7:4])) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= err_acc | w.user;
                            pkt_cnt      <= pkt_cnt + 32'd1;
                            err_acc      <= 1'b0;
                            state        <= HDR;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                            err_acc      <= err_acc | w.user;
                            if (w.last)
                                state <= TAIL;
                        end
                    end
                end

                TAIL: begin
                    if (can_emit) begin
                        m_axis_tdata  <= {32'h0, hold};
                        m_axis_tkeep  <= 8'h0F;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= err_acc;
                        m_axis_tvalid <= 1'b1;
                        pkt_cnt       <= pkt_cnt + 32'd1;
                        err_acc       <= 1'b0;
                        state         <= HDR;
                    end
                end

                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tlp_extract.sv
// Directed bench for eth_tlp_extract: FIFO model, stream
// capture and hand-built expected beats per frame type.
module tb_eth_tlp_extract;
    import eth_tlp_pkg::*;

    logic        user_clk = 1'b0;
    logic        user_reset;
    logic [73:0] dout;
    logic        empty;
    logic        rd_en;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    logic [73:0] fifo_q[$];
    logic [73:0] got_q[$];
    logic [73:0] exp_q[$];
    int          mode;
    int          stall_viol;
    int          n_chk;
    int          n_fail;

    always #5 user_clk = ~user_clk;

    eth_tlp_extract #(.HDR_WORDS(5), .C_DATA_WIDTH(64)) dut (
        .user_clk      (user_clk),
        .user_reset    (user_reset),
        .dout          (dout),
        .empty         (empty),
        .rd_en         (rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [73:0] mk(input logic [7:0] k,
                                       input logic [63:0] d,
                                       input logic l,
                                       input logic u);
        return {k, d, l, u};
    endfunction

    function automatic logic [31:0] dw(input logic [15:0] b,
                                       input int k);
        return {b, 16'(k)};
    endfunction

    // FIFO model, tready pattern and beat capture
    initial begin
        bit pop;
        bit gap;
        int cyc;
        cyc = 0;
        gap = 1'b0;
        dout = '0;
        empty = 1'b1;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge user_clk);
            pop = rd_en;
            if (m_axis_tvalid && m_axis_tready)
                got_q.push_back(mk(m_axis_tkeep, m_axis_tdata,
                                   m_axis_tlast, m_axis_tuser));
            if (m_axis_tvalid && !m_axis_tready && rd_en)
                stall_viol++;
            @(posedge user_clk);
            #1;
            cyc++;
            if (pop && fifo_q.size() > 0)
                void'(fifo_q.pop_front());
            case (mode)
                1: begin
                    m_axis_tready = cyc[0];
                    gap = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    m_axis_tready = 1'b0;
                    gap = 1'b0;
                end
                default: begin
                    m_axis_tready = 1'b1;
                    gap = 1'b0;
                end
            endcase
            dout  = fifo_q.size() > 0 ? fifo_q[0] : '0;
            empty = (fifo_q.size() == 0) || gap;
        end
    end

    task automatic push_hdr(input int n, input int err_word);
        for (int i = 0; i < n; i++)
            fifo_q.push_back(mk(8'hFF, 64'hE0E0_0000_0000_0000 | 64'(i),
                                1'b0, i == err_word));
    endtask

    task automatic mwr4(input logic [15:0] b, input int err_word);
        push_hdr(5, err_word);
        fifo_q.push_back(mk(8'hFF, {dw(b, 0), 32'hCAFE_0000}, 0, 0));
        fifo_q.push_back(mk(8'hFF, {dw(b, 2), dw(b, 1)}, 0, 0));
        fifo_q.push_back(mk(8'h0F, {32'hDEAD_BEEF, dw(b, 3)}, 1, 0));
        exp_q.push_back(mk(8'hFF, {dw(b, 1), dw(b, 0)}, 0, 0));
        exp_q.push_back(mk(8'hFF, {dw(b, 3), dw(b, 2)}, 1,
                           err_word >= 0));
    endtask

    task automatic rd3(input logic [15:0] b);
        push_hdr(5, -1);
        fifo_q.push_back(mk(8'hFF, {dw(b, 0), 32'hCAFE_0000}, 0, 0));
        fifo_q.push_back(mk(8'hFF, {dw(b, 2), dw(b, 1)}, 1, 0));
        exp_q.push_back(mk(8'hFF, {dw(b, 1), dw(b, 0)}, 0, 0));
        exp_q.push_back(mk(8'h0F, {32'h0, dw(b, 2)}, 1, 0));
    endtask

    task automatic drain();
        int idle;
        idle = 0;
        for (int i = 0; i < 2000 && idle < 4; i++) begin
            @(negedge user_clk);
            if (fifo_q.size() == 0 && !m_axis_tvalid)
                idle++;
            else
                idle = 0;
        end
        chk("drain_timeout", 96'(idle >= 4), 96'd1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nbeats"}, 96'(got_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_beat"}, 96'(got_q[i]), 96'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t;
        n_chk = 0;
        n_fail = 0;
        stall_viol = 0;
        mode = 0;
        user_reset = 1'b1;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_tvalid", 96'(m_axis_tvalid), 96'd0);
        chk("rst_tdata", 96'(m_axis_tdata), 96'd0);
        chk("rst_tkeep", 96'(m_axis_tkeep), 96'd0);
        chk("rst_tlast", 96'({m_axis_tlast, m_axis_tuser}), 96'd0);
        chk("rst_cnts", 96'({pkt_cnt, drop_cnt}), 96'd0);
        chk("rst_rd_en", 96'(rd_en), 96'd0);
        user_reset = 1'b0;

        mwr4(16'h1100, -1);
        drain();
        compare("mwr4");
        chk("mwr4_pkt", 96'(pkt_cnt), 96'd1);

        rd3(16'h2200);
        drain();
        compare("rd3");
        chk("rd3_pkt", 96'(pkt_cnt), 96'd2);

        mode = 1;
        stall_viol = 0;
        mwr4(16'h3300, -1);
        mwr4(16'h3400, -1);
        drain();
        compare("bp");
        chk("bp_stall_rd", 96'(stall_viol), 96'd0);
        chk("bp_pkt", 96'(pkt_cnt), 96'd4);
        mode = 0;

        for (int i = 0; i < 4; i++)
            fifo_q.push_back(mk(8'hFF, 64'(i), i == 3, 0));
        mwr4(16'h4400, -1);
        drain();
        compare("short");
        chk("short_drop", 96'(drop_cnt), 96'd1);
        chk("short_pkt", 96'(pkt_cnt), 96'd5);

        mwr4(16'h5500, 2);
        mwr4(16'h5600, -1);
        drain();
        compare("err");
        chk("err_pkt", 96'(pkt_cnt), 96'd7);

        push_hdr(5, -1);
        fifo_q.push_back(mk(8'hFF, {32'h6600_0000, 32'hCAFE_0000}, 1, 0));
        exp_q.push_back(mk(8'h0F, {32'h0, 32'h6600_0000}, 1, 0));
        push_hdr(5, -1);
        fifo_q.push_back(mk(8'h0F, {32'h0, 32'hCAFE_0000}, 1, 0));
        drain();
        compare("first");
        chk("first_pkt", 96'(pkt_cnt), 96'd8);
        chk("first_drop", 96'(drop_cnt), 96'd2);

        mode = 2;
        mwr4(16'h7700, -1);
        t = 0;
        while (dut.state != BODY && t < 200) begin
            @(negedge user_clk);
            t++;
        end
        chk("reach_body", 96'(dut.state == BODY), 96'd1);
        user_reset = 1'b1;
        fifo_q.delete();
        @(negedge user_clk);
        chk("mrst_tvalid", 96'(m_axis_tvalid), 96'd0);
        chk("mrst_tdata", 96'(m_axis_tdata), 96'd0);
        chk("mrst_cnts", 96'({pkt_cnt, drop_cnt}), 96'd0);
        chk("mrst_state", 96'(dut.state), 96'(HDR));
        chk("mrst_rd_en", 96'(rd_en), 96'd0);
        got_q.delete();
        exp_q.delete();
        mode = 0;
        @(negedge user_clk);
        user_reset = 1'b0;
        mwr4(16'h8800, -1);
        drain();
        compare("post_rst");
        chk("post_rst_pkt", 96'(pkt_cnt), 96'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tlp_extract.md
# eth_tlp_extract

Downstream stage of the Ethernet TLP tap FIFO. It pops 74-bit FIFO words of the form {keep[7:0], data[63:0], last, user}, each holding one Ethernet+IPv4+UDP frame beat, and discards the 44-byte encapsulation: a 42-byte header plus 2 pad bytes. It then realigns the remaining DW-aligned TLP by one DW and drives it as a 64-bit AXI4-Stream to the PCIe core transmit port, with full backpressure.

## Interface
- HDR_WORDS, 5: whole 64-bit words dropped before the TLP. The TLP starts at the upper DW of word HDR_WORDS.
- C_DATA_WIDTH, 64: stream width. Only 64 is supported.
- user_clk  in  1  single clock for all logic. The FIFO read side is in this domain.
- user_reset  in  1  synchronous, active-high reset.
- dout  in  74  FIFO word, first-word-fall-through: valid whenever !empty.
- empty  in  1  FIFO empty.
- rd_en  out  1  pops the current dout.
- m_axis_tdata  out  64  TLP data. Bits [31:0] carry the earlier DW.
- m_axis_tkeep  out  8  byte enables: 0xFF, or 0x0F on the final beat only.
- m_axis_tlast  out  1  last beat of TLP.
- m_axis_tuser  out  1  error flag, valid on the tlast beat.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- pkt_cnt  out  32  TLPs forwarded. Wraps modulo 2^32.
- drop_cnt  out  32  frames discarded as too short. Wraps modulo 2^32.

## Operation
- Word fields: keep=dout[73:66], data=dout[65:2], last=dout[1], user=dout[0]. Low DW (data[31:0], keep[3:0]) precedes the high DW on the wire.
- Pop rule: rd_en = !empty && accept, where accept = (!m_axis_tvalid || m_axis_tready) && state != TAIL.
- Every popped word ORs its user bit into err_acc. err_acc clears after each frame ends.
- States:
  - HDR: count popped words 0..HDR_WORDS-1.
    - Pop with last=1 → drop_cnt+1, count=0, stay in HDR.
    - Pop of word HDR_WORDS-1 → FIRST.
  - FIRST: pop word HDR_WORDS and store hold=data[63:32].
    - last=1 with keep[7:4]=0xF → emit {32'h0, data[63:32]}, keep 0x0F, tlast. This is a 1-DW tail; normal flow continues to HDR.
    - last=1 with keep[7:4]=0 → drop_cnt+1 → HDR.
    - Otherwise → BODY.
  - BODY: each pop emits tdata={cur[31:0], hold}, keep 0xFF, then hold=cur[63:32].
    - last=1 with keep=0x0F → this beat has tlast=1, pkt_cnt+1 → HDR.
    - last=1 with keep=0xFF → beat has tlast=0 → TAIL.
  - TAIL: no pop. Emit {32'h0, hold}, keep 0x0F, tlast=1, pkt_cnt+1 → HDR.
- m_axis_tuser on a tlast beat = err_acc OR the current word's user bit.
- Frames dropped as short never produce a beat.
- Keep values other than 0xFF/0x0F are not legal input. Any nonzero keep[7:4] is treated as 0xF.
- FIFO empty mid-frame: hold state and output register; no bubble-induced corruption.

## Timing
- Output is registered. A beat is valid the cycle after the pop that forms it. A TAIL beat is valid the cycle after the final BODY beat is accepted.
- Output registers hold stable while tvalid && !tready.
- Throughput is one word per cycle. A TLP whose last word is full costs one extra cycle (TAIL).
- Header words pop at full rate with no output activity.
- Reset values: rd_en=0, m_axis_tvalid=0, tdata/tkeep/tlast/tuser=0, pkt_cnt=0, drop_cnt=0, state=HDR, count=0, err_acc=0.
- Reset mid-frame: the partial frame is abandoned. The FIFO tail of that frame is parsed as a new frame; this is acceptable since the frame will end as a short drop or garbage flagged upstream.
- Simultaneous tready and pop: the new beat replaces the accepted one in the same edge.

## Structure
- Package eth_tlp_pkg:
  - packed struct fifo_word_t {keep[7:0], data[63:0], last, user};
  - localparam ENCAP_BYTES=44;
  - enum state_t {HDR, FIRST, BODY, TAIL}.
- Single module. No sub-module needed: the output register is the skid point because pops are gated by accept.

## Test plan
- 4-DW MWr: 5 header words, then word5 hi=D0, word6=D1|D2, word7 lo=D3 keep 0x0F last → beats {D1,D0} FF; {D3,D2} FF tlast; pkt_cnt=1.
- 3-DW read TLP: word5 hi=D0, word6=D1|D2 keep 0xFF last → {D1,D0} FF, then TAIL {0,D2} keep 0x0F tlast.
- Backpressure: tready toggled 1010 plus random empty gaps during the 4-DW MWr case → identical beats, no duplicates or losses, rd_en never high while the output is stalled.
- Short frame: last on word 3 → no output, drop_cnt=1. Next valid frame is forwarded normally.
- Error: user=1 on word 2 of the 4-DW MWr case → m_axis_tuser=1 on the tlast beat only. The following clean frame has tuser=0.
- Reset asserted mid-BODY → all outputs and counters 0 the next cycle; state=HDR.
